// File: rtl/clock_display_scan.sv
// Multiplexed 4-digit seven-segment scanner for an HH:MM counter chain with per-frame snapshot,
// illegal-time dash/err flagging and blinking colon. Optional macro: LEAD_ZERO_BLANK_EN.
module clock_display_scan #(
  parameter int SCAN_DIV     = 4,
  parameter int BLINK_FRAMES = 2
) (
  input  logic       clk,
  input  logic       clr_,
  input  logic [3:0] m0,
  input  logic [2:0] m1,
  input  logic [3:0] h0,
  input  logic [1:0] h1,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp,
  output logic       frame,
  output logic       err
);
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [6:0] SEG_DASH = 7'b1000000;
  localparam logic [6:0] SEG_ZERO = 7'b0111111;

  logic [PW-1:0] pre_reg, pre_next;
  logic [1:0]    idx_reg, idx_next;
  logic [FW-1:0] fcnt_reg, fcnt_next;
  logic          blink_reg, blink_next;
  logic [3:0]    s_m0_reg, s_m0_next;
  logic [2:0]    s_m1_reg, s_m1_next;
  logic [3:0]    s_h0_reg, s_h0_next;
  logic [1:0]    s_h1_reg, s_h1_next;
  logic [6:0]    seg_reg, seg_next;
  logic [3:0]    an_reg, an_next;
  logic          dp_reg, dp_next;
  logic          frame_reg, frame_next;
  logic          err_reg, err_next;
  logic          slot_wrap, boundary, h0_bad;

  function automatic logic [6:0] digit_seg(input logic [3:0] d);
    case (d)
      4'd0:    digit_seg = 7'b0111111;
      4'd1:    digit_seg = 7'b0000110;
      4'd2:    digit_seg = 7'b1011011;
      4'd3:    digit_seg = 7'b1001111;
      4'd4:    digit_seg = 7'b1100110;
      4'd5:    digit_seg = 7'b1101101;
      4'd6:    digit_seg = 7'b1111101;
      4'd7:    digit_seg = 7'b0000111;
      4'd8:    digit_seg = 7'b1111111;
      4'd9:    digit_seg = 7'b1101111;
      default: digit_seg = SEG_DASH;
    endcase
  endfunction

  // Timing chain and snapshot: everything downstream is decoded from next-state so that
  // an, seg and dp move on exactly the same edge as idx.
  always_comb begin
    slot_wrap  = (pre_reg == PW'(SCAN_DIV - 1));
    pre_next   = slot_wrap ? '0 : pre_reg + 1'b1;
    idx_next   = slot_wrap ? idx_reg + 2'd1 : idx_reg;
    boundary   = slot_wrap && (idx_reg == 2'd3);
    s_m0_next  = boundary ? m0 : s_m0_reg;
    s_m1_next  = boundary ? m1 : s_m1_reg;
    s_h0_next  = boundary ? h0 : s_h0_reg;
    s_h1_next  = boundary ? h1 : s_h1_reg;
    fcnt_next  = fcnt_reg;
    blink_next = blink_reg;
    if (boundary) begin
      if (fcnt_reg == FW'(BLINK_FRAMES - 1)) begin
        fcnt_next  = '0;
        blink_next = ~blink_reg;
      end else begin
        fcnt_next  = fcnt_reg + 1'b1;
      end
    end
  end

  always_comb begin
    h0_bad     = (s_h0_next > 4'd9) || ((s_h1_next == 2'd2) && (s_h0_next > 4'd3));
    err_next   = boundary ? ((s_m0_next > 4'd9) || (s_m1_next > 3'd5) || h0_bad ||
                             (s_h1_next > 2'd2)) : err_reg;
    frame_next = boundary;
    dp_next    = blink_next && (idx_next == 2'd2);
    unique case (idx_next)
      2'd0: seg_next = digit_seg(s_m0_next);
      2'd1: seg_next = (s_m1_next > 3'd5) ? SEG_DASH : digit_seg({1'b0, s_m1_next});
      2'd2: seg_next = h0_bad ? SEG_DASH : digit_seg(s_h0_next);
      default: begin
        if (s_h1_next > 2'd2)
          seg_next = SEG_DASH;
`ifdef LEAD_ZERO_BLANK_EN
        else if (s_h1_next == 2'd0)
          seg_next = 7'b0000000;
`endif
        else
          seg_next = digit_seg({2'b00, s_h1_next});
      end
    endcase
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_an
    assign an_next[gi] = (idx_next == gi[1:0]);
  end

  always_ff @(posedge clk or negedge clr_) begin
    if (!clr_) begin
      pre_reg   <= '0;
      idx_reg   <= '0;
      fcnt_reg  <= '0;
      blink_reg <= 1'b0;
      s_m0_reg  <= '0;
      s_m1_reg  <= '0;
      s_h0_reg  <= '0;
      s_h1_reg  <= '0;
      seg_reg   <= SEG_ZERO;
      an_reg    <= 4'b0001;
      dp_reg    <= 1'b0;
      frame_reg <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      pre_reg   <= pre_next;
      idx_reg   <= idx_next;
      fcnt_reg  <= fcnt_next;
      blink_reg <= blink_next;
      s_m0_reg  <= s_m0_next;
      s_m1_reg  <= s_m1_next;
      s_h0_reg  <= s_h0_next;
      s_h1_reg  <= s_h1_next;
      seg_reg   <= seg_next;
      an_reg    <= an_next;
      dp_reg    <= dp_next;
      frame_reg <= frame_next;
      err_reg   <= err_next;
    end
  end

  assign seg   = seg_reg;
  assign an    = an_reg;
  assign dp    = dp_reg;
  assign frame = frame_reg;
  assign err   = err_reg;
endmodule

// File: tb/tb_clock_display_scan.sv
// Scoreboard bench for clock_display_scan: a driver pushes the digits each frame will capture,
// a monitor checks every cycle of every frame against a digit-level reference model.
module tb_clock_display_scan;
  localparam int SD = 4;
  localparam int BF = 2;
  localparam int NF = 25;
  localparam int FL = 4 * SD;
  localparam int DASH = 'h40;

  logic       clk = 1'b0;
  logic       clr_;
  logic [3:0] m0, h0;
  logic [2:0] m1;
  logic [1:0] h1;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp, frame, err;

  typedef struct {
    int m0;
    int m1;
    int h0;
    int h1;
    int n;
  } rec_t;

  rec_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   pat[10] = '{'h3f, 'h06, 'h5b, 'h4f, 'h66, 'h6d, 'h7d, 'h07, 'h7f, 'h6f};
  int   dir_tab[5][4] = '{'{7, 4, 3, 1}, '{8, 4, 3, 1}, '{8, 4, 5, 2}, '{8, 6, 3, 1}, '{0, 2, 9, 0}};

  clock_display_scan #(.SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .clr_(clr_), .m0(m0), .m1(m1), .h0(h0), .h1(h1),
    .seg(seg), .an(an), .dp(dp), .frame(frame), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h required 0x%0h", name, $time, act, req);
    end
  endtask

  function automatic int ref_seg(input int slot, input rec_t r);
    if (slot == 0) return (r.m0 > 9) ? DASH : pat[r.m0];
    if (slot == 1) return (r.m1 > 5) ? DASH : pat[r.m1];
    if (slot == 2) return (r.h0 > 9 || (r.h1 == 2 && r.h0 > 3)) ? DASH : pat[r.h0];
    if (r.h1 > 2) return DASH;
`ifdef LEAD_ZERO_BLANK_EN
    if (r.h1 == 0) return 0;
`endif
    return pat[r.h1];
  endfunction

  function automatic int ref_err(input rec_t r);
    return (r.m0 > 9 || r.m1 > 5 || r.h0 > 9 || r.h1 > 2 || (r.h1 == 2 && r.h0 > 3)) ? 1 : 0;
  endfunction

  // Colon state after the n-th boundary: toggles every BF frames, starting low.
  function automatic int ref_blink(input int n);
    return (n / BF) % 2;
  endfunction

  task automatic drive(input int a, input int b, input int c, input int d);
    m0 = 4'(a); m1 = 3'(b); h0 = 4'(c); h1 = 2'(d);
  endtask

  task automatic run_driver();
    rec_t r;
    int   c1, c2;
    for (int n = 1; n <= NF; n++) begin
      if (n <= 5) begin
        r = '{dir_tab[n-1][0], dir_tab[n-1][1], dir_tab[n-1][2], dir_tab[n-1][3], n};
      end else if (n == NF) begin
        r = '{3, 2, 1, 3, n};
      end else if ($urandom_range(0, 3) == 0) begin
        r = '{$urandom_range(0, 15), $urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 3), n};
      end else begin
        r.h1 = $urandom_range(0, 2);
        r = '{$urandom_range(0, 9), $urandom_range(0, 5), $urandom_range(0, (r.h1 == 2) ? 3 : 9), r.h1, n};
      end
      c1 = $urandom_range(0, FL/2 - 1);
      c2 = $urandom_range(FL/2, FL - 1);
      for (int c = 0; c < FL; c++) begin
        if (!(n == 1 && c == 0)) @(negedge clk);
        if (c == c1)
          drive($urandom_range(0, 15), $urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 3));
        if (c == c2) drive(r.m0, r.m1, r.h0, r.h1);
        if (c == FL - 1) exp_q.push_back(r);
      end
    end
  endtask

  task automatic run_monitor();
    rec_t cur;
    int   slot;
    cur = '{0, 0, 0, 0, 0};
    for (int f = 0; f <= NF; f++) begin
      for (int c = 0; c < FL; c++) begin
        if (!(f == 0 && c == 0)) @(negedge clk);
        if (c == 0 && f > 0) begin
          if (exp_q.size() == 0) check("queue_empty", 0, 1);
          else cur = exp_q.pop_front();
        end
        slot = c / SD;
        check("frame", int'(frame), (c == 0 && f > 0) ? 1 : 0);
        check("an", int'(an), 1 << slot);
        check("seg", int'(seg), ref_seg(slot, cur));
        check("dp", int'(dp), (slot == 2) ? ref_blink(cur.n) : 0);
        check("err", int'(err), ref_err(cur));
      end
    end
  endtask

  initial begin
    int k;
    clr_ = 1'b0;
    drive(0, 0, 0, 0);
    repeat (3) @(negedge clk);
    clr_ = 1'b1;
    fork
      run_driver();
      run_monitor();
    join
    // Frame NF+1 holds an illegal snapshot with the colon lit; reset it mid h0-slot.
    @(negedge clk);
    repeat (2 * SD + 1) @(negedge clk);
    check("pre_rst_an", int'(an), 4);
    check("pre_rst_dp", int'(dp), ref_blink(NF + 1));
    check("pre_rst_err", int'(err), 1);
    #2 clr_ = 1'b0;
    #1;
    check("rst_an", int'(an), 1);
    check("rst_seg", int'(seg), 'h3f);
    check("rst_dp", int'(dp), 0);
    check("rst_err", int'(err), 0);
    check("rst_frame", int'(frame), 0);
    @(negedge clk);
    clr_ = 1'b1;
    k = 0;
    for (int i = 1; i <= 3 * FL; i++) begin
      @(negedge clk);
      if (frame) begin
        k = i;
        break;
      end
      if (i == FL - 1) check("rst_zero_seg", int'(seg), 'h3f);
    end
    check("rst_first_frame", k, FL);
    check("rst_next_err", int'(err), 1);
    check("rst_next_seg_m0", int'(seg), pat[3]);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
